// File: rtl/usbdev_remote_wake_ctrl_pkg.sv
// Shared types and default timing for the USB remote-wakeup sequencer.
package usbdev_pkg;

  typedef enum logic [2:0] {
    WkIdle     = 3'd0,
    WkArm      = 3'd1,
    WkDriveK   = 3'd2,
    WkRelease  = 3'd3,
    WkWaitHost = 3'd4
  } wake_state_e;

  localparam int unsigned IdleMinUsDef     = 5000;
  localparam int unsigned DriveKUsDef      = 2000;
  localparam int unsigned HostTimeoutUsDef = 25000;
  localparam int unsigned TimerWDef        = 15;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usbdev_remote_wake_ctrl_if.sv
// Signal bundle between software/link detector (master) and the wakeup sequencer (slave).
interface usbdev_remote_wake_ctrl_if;
  import usbdev_pkg::*;

  logic        us_tick_i;
  logic        wake_req_i;
  logic        wake_abort_i;
  logic        link_suspend_i;
  logic        link_active_i;
  logic        link_reset_i;
  logic        link_disconnect_i;
  logic        drive_k_o;
  logic        resume_link_active_o;
  logic        wake_busy_o;
  logic        wake_done_o;
  logic        wake_fail_o;
  wake_state_e wake_state_o;

  modport master (
    output us_tick_i, wake_req_i, wake_abort_i, link_suspend_i,
           link_active_i, link_reset_i, link_disconnect_i,
    input  drive_k_o, resume_link_active_o, wake_busy_o, wake_done_o,
           wake_fail_o, wake_state_o
  );

  modport slave (
    input  us_tick_i, wake_req_i, wake_abort_i, link_suspend_i,
           link_active_i, link_reset_i, link_disconnect_i,
    output drive_k_o, resume_link_active_o, wake_busy_o, wake_done_o,
           wake_fail_o, wake_state_o
  );

endinterface

// File: rtl/usbdev_remote_wake_ctrl_us_timer.sv
// Microsecond tick counter with synchronous clear; hit flags count == limit.
module usbdev_us_timer #(
  parameter int unsigned TimerW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [TimerW-1:0] limit,
  output logic              hit
);

  logic [TimerW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TimerW'(1);
    end
  end

  assign hit = (count == limit);

endmodule

// File: rtl/usbdev_remote_wake_ctrl.sv
// Device-initiated USB remote wakeup: enforce bus idle, drive K, release, hand over to host.
// All outputs registered; reset asserts asynchronously and releases through a 2-flop synchronizer.
module usbdev_remote_wake_ctrl
  import usbdev_pkg::*;
#(
  parameter int unsigned IdleMinUs     = IdleMinUsDef,
  parameter int unsigned DriveKUs      = DriveKUsDef,
  parameter int unsigned HostTimeoutUs = HostTimeoutUsDef,
  parameter int unsigned TimerW        = TimerWDef
) (
  input logic                      clk_48mhz_i,
  input logic                      rst_i,
  usbdev_remote_wake_ctrl_if.slave bus
);

  if ((64'd1 << TimerW) <= 64'(max3(IdleMinUs, DriveKUs, HostTimeoutUs))) begin : g_timer_w_chk
    $error("TimerW is too narrow for the configured phase lengths");
  end

  // Terminal counts are N-1 so that each phase spans exactly N ticks.
  localparam logic [TimerW-1:0] IdleTc = TimerW'(IdleMinUs - 1);
  localparam logic [TimerW-1:0] DriveTc = TimerW'(DriveKUs - 1);
  localparam logic [TimerW-1:0] HostTc = TimerW'(HostTimeoutUs - 1);

  logic [1:0] rst_q;
  logic       rst;

  always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
    if (rst_i) begin
      rst_q <= 2'b11;
    end else begin
      rst_q <= {rst_q[0], 1'b0};
    end
  end

  assign rst = rst_q[1];

  wake_state_e       state;
  logic              drive_k;
  logic              resume_pulse;
  logic              busy;
  logic              done_pulse;
  logic              fail_pulse;

  logic              abort_hit;
  logic              done_hit;
  logic              counting;
  logic              tmr_en;
  logic              tmr_clr;
  logic              tmr_hit;
  logic              tmr_expire;
  logic              leave;
  logic [TimerW-1:0] tmr_lim;

  assign abort_hit = bus.wake_abort_i | bus.link_reset_i | bus.link_disconnect_i;

  // A bus reset seen together with link active is the host finishing resume, not an abort.
  assign done_hit = (state == WkWaitHost) & bus.link_active_i &
                    ~bus.wake_abort_i & ~bus.link_disconnect_i;

  always_comb begin
    tmr_lim  = '0;
    counting = 1'b0;
    case (state)
      WkArm: begin
        tmr_lim  = IdleTc;
        counting = bus.link_suspend_i;
      end
      WkDriveK: begin
        tmr_lim  = DriveTc;
        counting = 1'b1;
      end
      WkWaitHost: begin
        tmr_lim  = HostTc;
        counting = 1'b1;
      end
      default: begin
        tmr_lim  = '0;
        counting = 1'b0;
      end
    endcase
  end

  assign tmr_en     = bus.us_tick_i & counting;
  assign tmr_expire = tmr_en & tmr_hit;
  assign leave      = (state != WkIdle) &
                      (abort_hit | done_hit | tmr_expire | (state == WkRelease));
  // Idle holds the timer at zero so every phase starts from a clean count.
  assign tmr_clr    = (state == WkIdle) | leave |
                      ((state == WkArm) & ~bus.link_suspend_i);

  usbdev_us_timer #(
    .TimerW(TimerW)
  ) u_timer (
    .clk  (clk_48mhz_i),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .limit(tmr_lim),
    .hit  (tmr_hit)
  );

  always_ff @(posedge clk_48mhz_i or posedge rst) begin
    if (rst) begin
      state        <= WkIdle;
      drive_k      <= 1'b0;
      resume_pulse <= 1'b0;
      busy         <= 1'b0;
      done_pulse   <= 1'b0;
      fail_pulse   <= 1'b0;
    end else begin
      resume_pulse <= 1'b0;
      done_pulse   <= 1'b0;
      fail_pulse   <= 1'b0;
      if (state == WkIdle) begin
        if (bus.wake_req_i && !bus.wake_abort_i) begin
          state <= WkArm;
          busy  <= 1'b1;
        end
      end else if (done_hit) begin
        state      <= WkIdle;
        busy       <= 1'b0;
        drive_k    <= 1'b0;
        done_pulse <= 1'b1;
      end else if (abort_hit) begin
        state      <= WkIdle;
        busy       <= 1'b0;
        drive_k    <= 1'b0;
        fail_pulse <= 1'b1;
      end else begin
        case (state)
          WkArm: begin
            if (tmr_expire) begin
              state   <= WkDriveK;
              drive_k <= 1'b1;
            end
          end
          WkDriveK: begin
            if (tmr_expire) begin
              state        <= WkRelease;
              drive_k      <= 1'b0;
              resume_pulse <= 1'b1;
            end
          end
          WkRelease: begin
            state <= WkWaitHost;
          end
          WkWaitHost: begin
            if (tmr_expire) begin
              state      <= WkIdle;
              busy       <= 1'b0;
              fail_pulse <= 1'b1;
            end
          end
          default: begin
            state   <= WkIdle;
            busy    <= 1'b0;
            drive_k <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.drive_k_o            = drive_k;
  assign bus.resume_link_active_o = resume_pulse;
  assign bus.wake_busy_o          = busy;
  assign bus.wake_done_o          = done_pulse;
  assign bus.wake_fail_o          = fail_pulse;
  assign bus.wake_state_o         = state;

endmodule

// File: tb/tb_usbdev_remote_wake_ctrl.sv
// Scoreboard bench: stimulus pushes expected output events (timed in ticks or cycles), a monitor pops them.
module tb_usbdev_remote_wake_ctrl;

  localparam int IDLE_N = 5000;
  localparam int DRIVE_N = 2000;
  localparam int HOST_N = 25000;

  typedef enum int {EV_RISE, EV_FALL, EV_RES, EV_DONE, EV_FAIL} ev_e;
  typedef struct {
    ev_e kind;
    int  when;      // negative: same cycle as the previous observed event
    bit  by_cycle;  // 1: when is a cycle number, 0: when is a tick count
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  usbdev_remote_wake_ctrl_if bus();

  usbdev_remote_wake_ctrl #(
    .IdleMinUs    (IDLE_N),
    .DriveKUs     (DRIVE_N),
    .HostTimeoutUs(HOST_N),
    .TimerW       (15)
  ) dut (
    .clk_48mhz_i(clk),
    .rst_i      (rst),
    .bus        (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tick_cnt = 0;
  int   last_ev_cyc = 0;
  bit   gap_en = 1'b0;
  bit   mon_dk = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.us_tick_i) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    bus.us_tick_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.us_tick_i = gap_en ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input ev_e k, input int when, input bit by_cycle);
    exp_t e;
    e.kind = k;
    e.when = when;
    e.by_cycle = by_cycle;
    sb.push_back(e);
  endtask

  task automatic take(input ev_e k);
    exp_t e;
    int now, want;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required none", k.name(), cyc);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (e.when < 0) begin
      now = cyc;
      want = last_ev_cyc;
    end else if (e.by_cycle) begin
      now = cyc;
      want = e.when;
    end else begin
      now = tick_cnt;
      want = e.when;
    end
    chk($sformatf("time_%s", e.kind.name()), now, want);
    case (k)
      EV_RISE: chk("state_at_rise", int'(bus.wake_state_o), 2);
      EV_RES:  chk("state_at_resume", int'(bus.wake_state_o), 3);
      EV_DONE, EV_FAIL: begin
        chk($sformatf("state_at_%s", k.name()), int'(bus.wake_state_o), 0);
        chk($sformatf("busy_at_%s", k.name()), int'(bus.wake_busy_o), 0);
      end
      default: ;
    endcase
    last_ev_cyc = cyc;
  endtask

  // Monitor: every visible output event must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_dk = 1'b0;
      end else begin
        if (bus.drive_k_o && !mon_dk) take(EV_RISE);
        if (!bus.drive_k_o && mon_dk) take(EV_FALL);
        if (bus.resume_link_active_o) take(EV_RES);
        if (bus.wake_done_o) take(EV_DONE);
        if (bus.wake_fail_o) take(EV_FAIL);
        mon_dk = bus.drive_k_o;
      end
    end
  end

  task automatic wait_tick(input int t);
    int n = 0;
    while (tick_cnt < t && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (tick_cnt < t) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: tick %0d required %0d", tick_cnt, t);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic start(output int base);
    bus.wake_req_i = 1'b1;
    @(negedge clk);
    bus.wake_req_i = 1'b0;
    base = tick_cnt;
  endtask

  task automatic push_k_cycle(input int base);
    push(EV_RISE, base + IDLE_N, 1'b0);
    push(EV_FALL, base + IDLE_N + DRIVE_N, 1'b0);
    push(EV_RES, -1, 1'b1);
  endtask

  initial begin
    int base, r;
    bus.wake_req_i = 1'b0;
    bus.wake_abort_i = 1'b0;
    bus.link_suspend_i = 1'b0;
    bus.link_active_i = 1'b0;
    bus.link_reset_i = 1'b0;
    bus.link_disconnect_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_drive_k", int'(bus.drive_k_o), 0);
    chk("rst_resume", int'(bus.resume_link_active_o), 0);
    chk("rst_busy", int'(bus.wake_busy_o), 0);
    chk("rst_done", int'(bus.wake_done_o), 0);
    chk("rst_fail", int'(bus.wake_fail_o), 0);
    chk("rst_state", int'(bus.wake_state_o), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Nominal, with sparse ticks and a redundant request while armed.
    gap_en = 1'b1;
    bus.link_suspend_i = 1'b1;
    repeat (5) @(negedge clk);
    start(base);
    chk("arm_state", int'(bus.wake_state_o), 1);
    chk("arm_busy", int'(bus.wake_busy_o), 1);
    push_k_cycle(base);
    wait_tick(base + int'($urandom_range(10, 4000)));
    start(r);
    drain(20000);
    wait_tick(base + IDLE_N + DRIVE_N + 100);
    bus.link_active_i = 1'b1;
    push(EV_DONE, cyc + 1, 1'b1);
    @(negedge clk);
    bus.link_active_i = 1'b0;
    drain(10);
    chk("nominal_end_busy", int'(bus.wake_busy_o), 0);

    // Request before suspend: idle count starts when suspend appears.
    bus.link_suspend_i = 1'b0;
    @(negedge clk);
    start(base);
    chk("unsuspended_state", int'(bus.wake_state_o), 1);
    wait_tick(base + 300);
    bus.link_suspend_i = 1'b1;
    base = tick_cnt;
    push_k_cycle(base);
    drain(20000);
    wait_tick(tick_cnt + int'($urandom_range(1, 200)));
    bus.link_active_i = 1'b1;
    push(EV_DONE, cyc + 1, 1'b1);
    @(negedge clk);
    bus.link_active_i = 1'b0;
    drain(10);

    // One-cycle suspend glitch at idle tick 4000; finish with reset+active (done wins).
    gap_en = 1'b0;
    start(base);
    wait_tick(base + 4000);
    bus.link_suspend_i = 1'b0;
    @(negedge clk);
    bus.link_suspend_i = 1'b1;
    base = tick_cnt;
    push_k_cycle(base);
    drain(20000);
    @(negedge clk);
    bus.link_reset_i = 1'b1;
    bus.link_active_i = 1'b1;
    push(EV_DONE, cyc + 1, 1'b1);
    @(negedge clk);
    bus.link_reset_i = 1'b0;
    bus.link_active_i = 1'b0;
    drain(10);

    // Bus reset 1000 ticks into K drive.
    start(base);
    push(EV_RISE, base + IDLE_N, 1'b0);
    wait_tick(base + IDLE_N + 1000);
    bus.link_reset_i = 1'b1;
    push(EV_FALL, cyc + 1, 1'b1);
    push(EV_FAIL, cyc + 1, 1'b1);
    @(negedge clk);
    bus.link_reset_i = 1'b0;
    chk("busreset_drive_k", int'(bus.drive_k_o), 0);
    chk("busreset_state", int'(bus.wake_state_o), 0);
    drain(10);

    // Software abort while armed, then disconnect while waiting for suspend.
    start(base);
    wait_tick(base + int'($urandom_range(1, 3000)));
    bus.wake_abort_i = 1'b1;
    push(EV_FAIL, cyc + 1, 1'b1);
    @(negedge clk);
    bus.wake_abort_i = 1'b0;
    drain(10);
    bus.link_suspend_i = 1'b0;
    start(base);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    bus.link_disconnect_i = 1'b1;
    push(EV_FAIL, cyc + 1, 1'b1);
    @(negedge clk);
    bus.link_disconnect_i = 1'b0;
    bus.link_suspend_i = 1'b1;
    drain(10);

    // Request and abort together in idle: nothing happens.
    bus.wake_req_i = 1'b1;
    bus.wake_abort_i = 1'b1;
    @(negedge clk);
    bus.wake_req_i = 1'b0;
    bus.wake_abort_i = 1'b0;
    @(negedge clk);
    chk("req_abort_state", int'(bus.wake_state_o), 0);
    chk("req_abort_busy", int'(bus.wake_busy_o), 0);

    // Async reset mid K drive, then a full sequence that times out on the host.
    start(base);
    push_k_cycle(base);
    wait_tick(base + IDLE_N + int'($urandom_range(10, 1500)));
    #5;
    sb.delete();
    rst = 1'b1;
    #1;
    chk("async_rst_drive_k", int'(bus.drive_k_o), 0);
    chk("async_rst_busy", int'(bus.wake_busy_o), 0);
    chk("async_rst_state", int'(bus.wake_state_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start(base);
    push_k_cycle(base);
    push(EV_FAIL, base + IDLE_N + DRIVE_N + 1 + HOST_N, 1'b0);
    drain(40000);
    chk("timeout_state", int'(bus.wake_state_o), 0);

    repeat (20) @(negedge clk);
    chk("leftover_expectations", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usbdev_remote_wake_ctrl.md
Name: usbdev_remote_wake_ctrl

Overview:
- Sequences device-initiated USB remote wakeup: on a software request while the link is suspended, it enforces the minimum bus-idle time, drives K on the bus for a fixed duration, releases the bus, and waits for the host to take over resume signaling and return the link to active.
- Sits between the CSR/software wake request, the link-state detector's level outputs, and the transceiver output mux.
- It is the only block allowed to drive resume K.

Parameters:
- IdleMinUs, 5000: minimum continuous suspend time in microseconds before K may be driven (USB spec: 5 ms).
- DriveKUs, 2000: duration of device-driven K in microseconds (spec window: 1–15 ms).
- HostTimeoutUs, 25000: maximum wait for the link to go active after K is released.
- TimerW, 15: timer width. Must satisfy 2^TimerW > max(IdleMinUs, DriveKUs, HostTimeoutUs); checked by an elaboration-time assertion.

Ports:
- clk_48mhz_i  in  1  48 MHz clock
- rst_i  in  1  active-high asynchronous reset
- us_tick_i  in  1  single-cycle 1 µs tick
- wake_req_i  in  1  software wake request pulse
- wake_abort_i  in  1  software abort pulse
- link_suspend_i  in  1  link suspended (level)
- link_active_i  in  1  link active (level)
- link_reset_i  in  1  bus reset in progress (level)
- link_disconnect_i  in  1  link disconnected (level)
- drive_k_o  in-mux  out  1  force K onto the bus (registered)
- resume_link_active_o  out  1  one-cycle pulse to the link detector on K release
- wake_busy_o  out  1  sequence in progress (level)
- wake_done_o  out  1  one-cycle pulse: link active after wakeup
- wake_fail_o  out  1  one-cycle pulse: sequence aborted or timed out
- wake_state_o  out  3  current FSM state encoding

Behaviour:
- Reset values: all outputs 0; FSM in WkIdle; timer 0.
- Reset is asynchronous assert, synchronous deassert. Reset mid-sequence drops drive_k_o immediately and produces no pulses.
- All outputs are registered. Pulses last exactly one cycle.
- Timer advances only on us_tick_i and is cleared on every state entry. Comparisons use ==, with terminal count N-1, so each phase lasts exactly N ticks.

FSM:
- WkIdle: on wake_req_i go to WkArm. If link_suspend_i=1 at that point, the idle timer starts at that cycle; otherwise the FSM waits in WkArm for suspend.
- WkArm: counts continuous link_suspend_i. The timer clears whenever link_suspend_i=0. After IdleMinUs ticks, go to WkDriveK. A wake_req_i already pending is ignored (no queueing).
- WkDriveK: drive_k_o=1 starting the cycle after entry. After DriveKUs ticks, go to WkRelease.
- WkRelease: one cycle. drive_k_o=0, resume_link_active_o=1. Go to WkWaitHost.
- WkWaitHost: when link_active_i=1, emit wake_done_o and go to WkIdle. After HostTimeoutUs ticks without link_active_i, emit wake_fail_o and go to WkIdle.
- Abort: in any non-Idle state, wake_abort_i, link_reset_i or link_disconnect_i causes wake_fail_o, drive_k_o=0 the next cycle, and a return to WkIdle. This takes priority over all other transitions in the same cycle.
- Exception: link_reset_i during WkWaitHost counts as host resume completion only if link_active_i is also 1 in that cycle; then wake_done_o takes priority.
- wake_busy_o = (state != WkIdle).
- Simultaneous wake_req_i and wake_abort_i in WkIdle: abort wins, stay in WkIdle, no pulse.

Decomposition:
- Package usbdev_pkg holds: typedef wake_state_e (WkIdle=0, WkArm=1, WkDriveK=2, WkRelease=3, WkWaitHost=4) and the default timing constants.
- One sub-module: usbdev_us_timer, a TimerW-bit tick counter with clear, enable and terminal-count compare, instanced once and shared across states.

Test Plan:
- Nominal: suspend held, wake_req pulse → drive_k_o rises after 5000 ticks and stays high exactly 2000 ticks; resume_link_active_o pulses once; link_active_i raised 100 ticks later → wake_done_o pulses once; busy=0.
- Not suspended: wake_req while link_suspend_i=0, suspend asserted at tick 300 → drive_k_o rises 5000 ticks after tick 300, not after the request.
- Suspend glitch: link_suspend_i drops for 1 cycle at idle tick 4000 → idle count restarts; drive_k_o rises 5000 ticks after the glitch.
- Host timeout: link_active_i never rises → wake_fail_o pulses 25000 ticks after K release; no wake_done_o.
- Bus reset during WkDriveK at tick 1000 → drive_k_o=0 the next cycle, wake_fail_o pulse, state WkIdle.
- Async rst_i asserted mid-WkDriveK → drive_k_o=0 immediately, no pulses; a new wake_req after reset release runs the full sequence.
